// File: rtl/gshare_pht_ctrl_if.sv
// Fetch/resolve-side bundle for the gshare pattern-history-table controller.
// The master side is the pipeline (fetch issues lookups, branch resolution
// issues training updates); the slave side is gshare_pht_ctrl.
interface gshare_pht_ctrl_if #(
    parameter int IDX_W    = 7,
    parameter int HIST_W   = 7,
    parameter int TQ_DEPTH = 4
);
    localparam int CNT_W = $clog2(TQ_DEPTH) + 1;

    // Lookup request / result
    logic              predict_valid;
    logic [IDX_W-1:0]  predict_pc;
    logic              predict_ready;
    logic              pred_out_valid;
    logic              pred_out_taken;
    logic [IDX_W-1:0]  pred_out_idx;

    // Training update
    logic              train_valid;
    logic [IDX_W-1:0]  train_idx;
    logic              train_taken;
    logic              train_ready;

    // Status
    logic              init_done;
    logic [HIST_W-1:0] ghr;
    logic [CNT_W-1:0]  tq_count;

    modport master (
        output predict_valid, predict_pc,
        output train_valid, train_idx, train_taken,
        input  predict_ready, pred_out_valid, pred_out_taken, pred_out_idx,
        input  train_ready, init_done, ghr, tq_count
    );

    modport slave (
        input  predict_valid, predict_pc,
        input  train_valid, train_idx, train_taken,
        output predict_ready, pred_out_valid, pred_out_taken, pred_out_idx,
        output train_ready, init_done, ghr, tq_count
    );
endinterface

// File: rtl/gshare_pht_ctrl.sv
// gshare pattern-history-table controller.
// Owns a table of 2**IDX_W two-bit saturating counters, sweeps it to INIT_VAL
// after reset, then serves one table access per cycle: a lookup (read,
// registered result) or, when no lookup is accepted, the head of the training
// queue (read-modify-write). The global history register shifts only on
// training drains, so it reflects resolved branches in arrival order.
// HIST_W must lie in 1..IDX_W; TQ_DEPTH must be a power of two >= 2.
module gshare_pht_ctrl #(
    parameter int         IDX_W    = 7,
    parameter int         HIST_W   = 7,
    parameter int         TQ_DEPTH = 4,
    parameter logic [1:0] INIT_VAL = 2'd1
) (
    input logic            clk,
    input logic            areset,
    gshare_pht_ctrl_if.slave bus
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int PTR_W = $clog2(TQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] TQ_FULL    = CNT_W'(TQ_DEPTH);
    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Two-bit saturating counter step: no wrap at either end.
    function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken && (cur != 2'd3)) begin
            nxt = cur + 2'd1;
        end else if (!taken && (cur != 2'd0)) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

    // Control state
    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  sweep_ptr_q, sweep_ptr_d;
    logic              init_done_q, init_done_d;
    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [CNT_W-1:0]  tq_count_q, tq_count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              pred_vld_q, pred_vld_d;
    logic              pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0]  pred_idx_q, pred_idx_d;

    // Storage (not reset; the INIT sweep and queue pointers define validity)
    logic [1:0]        pht_q [DEPTH];
    logic [IDX_W-1:0]  tq_idx_q [TQ_DEPTH];
    logic              tq_taken_q [TQ_DEPTH];

    // Per-cycle decisions
    logic              run;
    logic              not_full;
    logic              pred_acc;
    logic              enq;
    logic              drain;
    logic [IDX_W-1:0]  lookup_idx;
    logic [IDX_W-1:0]  head_idx;
    logic              head_taken;
    logic              pht_we;
    logic [IDX_W-1:0]  pht_wa;
    logic [1:0]        pht_wd;

    assign run      = (state_q == ST_RUN);
    assign not_full = (tq_count_q != TQ_FULL);

    // A full queue blocks lookups so the drain slot is guaranteed.
    assign bus.predict_ready = run && not_full;
    assign bus.train_ready   = run && not_full;

    assign pred_acc = bus.predict_valid && run && not_full;
    assign enq      = bus.train_valid && run && not_full;
    assign drain    = run && !pred_acc && (tq_count_q != '0);

    assign lookup_idx = bus.predict_pc ^ IDX_W'(ghr_q);
    assign head_idx   = tq_idx_q[rd_ptr_q];
    assign head_taken = tq_taken_q[rd_ptr_q];

    assign bus.pred_out_valid = pred_vld_q;
    assign bus.pred_out_taken = pred_taken_q;
    assign bus.pred_out_idx   = pred_idx_q;
    assign bus.init_done      = init_done_q;
    assign bus.ghr            = ghr_q;
    assign bus.tq_count       = tq_count_q;

    // Single table write port: the init sweep or a training drain, never both.
    always_comb begin
        pht_we = 1'b0;
        pht_wa = '0;
        pht_wd = '0;
        if (state_q == ST_INIT) begin
            pht_we = 1'b1;
            pht_wa = sweep_ptr_q;
            pht_wd = INIT_VAL;
        end else if (drain) begin
            pht_we = 1'b1;
            pht_wa = head_idx;
            pht_wd = sat_update(pht_q[head_idx], head_taken);
        end
    end

    // Next-state for the sweep, queue bookkeeping, history and lookup result.
    always_comb begin
        state_d      = state_q;
        sweep_ptr_d  = sweep_ptr_q;
        init_done_d  = init_done_q;
        ghr_d        = ghr_q;
        tq_count_d   = tq_count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        pred_vld_d   = pred_acc;
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;

        if (state_q == ST_INIT) begin
            sweep_ptr_d = sweep_ptr_q + IDX_W'(1);
            if (sweep_ptr_q == SWEEP_LAST) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end

        if (pred_acc) begin
            pred_taken_d = pht_q[lookup_idx][1];
            pred_idx_d   = lookup_idx;
        end

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (drain) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            ghr_d    = (ghr_q << 1) | HIST_W'(head_taken);
        end

        case ({enq, drain})
            2'b10:   tq_count_d = tq_count_q + CNT_W'(1);
            2'b01:   tq_count_d = tq_count_q - CNT_W'(1);
            default: tq_count_d = tq_count_q;
        endcase
    end

    // Control registers; asynchronous reset restarts the init sweep and empties the queue.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_INIT;
            sweep_ptr_q  <= '0;
            init_done_q  <= 1'b0;
            ghr_q        <= '0;
            tq_count_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            pred_vld_q   <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            sweep_ptr_q  <= sweep_ptr_d;
            init_done_q  <= init_done_d;
            ghr_q        <= ghr_d;
            tq_count_q   <= tq_count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            pred_vld_q   <= pred_vld_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
        end
    end

    // Counter table write port.
    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht_q[pht_wa] <= pht_wd;
        end
    end

    // Training queue payload write; occupancy lives in the control registers.
    always_ff @(posedge clk) begin
        if (enq) begin
            tq_idx_q[wr_ptr_q]   <= bus.train_idx;
            tq_taken_q[wr_ptr_q] <= bus.train_taken;
        end
    end

endmodule
